// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - six-digit multiplexed seven-segment scanner for HH.MM.SS with field blink
module clock_display_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [5:0] i_count_h,
   input  logic [5:0] i_count_m,
   input  logic [5:0] i_count_s,
   input  logic       i_mode,
   input  logic       i_set,
   input  logic       i_hour,
   input  logic       i_min,
   input  logic       i_sec,
   output logic [5:0] o_an,
   output logic [6:0] o_seg,
   output logic       o_dp
);

   localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [SW-1:0] r_scnt;
   logic [2:0]    r_idx;
   logic [BW-1:0] r_bcnt;
   logic          r_blink_on;
   logic [5:0]    r_snap_h, r_snap_m, r_snap_s;
   logic [5:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;

   logic [5:0] w_val;
   logic [3:0] w_tens, w_ones, w_digit;
   logic       w_sel, w_blank, w_sep;
   logic [5:0] w_an;
   logic [6:0] w_seg;

   function automatic logic [3:0] f_tens(input logic [5:0] v);
      if      (v >= 6'd60) return 4'd6;
      else if (v >= 6'd50) return 4'd5;
      else if (v >= 6'd40) return 4'd4;
      else if (v >= 6'd30) return 4'd3;
      else if (v >= 6'd20) return 4'd2;
      else if (v >= 6'd10) return 4'd1;
      else                 return 4'd0;
   endfunction

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   always_comb begin
      w_val = r_snap_s;
      w_sel = i_sec;
      case (r_idx)
         3'd0, 3'd1: begin w_val = r_snap_h; w_sel = i_hour; end
         3'd2, 3'd3: begin w_val = r_snap_m; w_sel = i_min;  end
         default:    begin w_val = r_snap_s; w_sel = i_sec;  end
      endcase
      w_tens  = f_tens(w_val);
      w_ones  = 4'(w_val - 6'(w_tens * 4'd10));
      w_digit = r_idx[0] ? w_ones : w_tens;
      w_seg   = f_seg(w_digit);
      // Slot start is blanked so the previous digit's segments never ghost onto the next anode
      w_blank = (r_scnt == '0) || (i_set && !r_blink_on && w_sel);
      w_sep   = (r_idx == 3'd1) || (r_idx == 3'd3) || (!i_mode && r_idx == 3'd5);
      w_an    = w_blank ? 6'b111111 : ~(6'b100000 >> r_idx);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_scnt     <= '0;
         r_idx      <= 3'd0;
         r_bcnt     <= '0;
         r_blink_on <= 1'b1;
         r_snap_h   <= 6'd0;
         r_snap_m   <= 6'd0;
         r_snap_s   <= 6'd0;
         r_an       <= 6'b111111;
         r_seg      <= 7'b1111111;
         r_dp       <= 1'b1;
      end else begin
         r_an  <= w_an;
         r_seg <= w_seg;
         r_dp  <= w_blank ? 1'b1 : !w_sep;

         if (r_scnt == SCAN_LAST) begin
            r_scnt <= '0;
            r_idx  <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            // Latch at the very end of a frame so each frame shows one coherent time
            if (r_idx == 3'd5) begin
               r_snap_h <= i_count_h;
               r_snap_m <= i_count_m;
               r_snap_s <= i_count_s;
            end
         end else begin
            r_scnt <= r_scnt + 1'b1;
         end

         if (!i_set) begin
            r_bcnt     <= '0;
            r_blink_on <= 1'b1;
         end else if (r_bcnt == BLINK_LAST) begin
            r_bcnt     <= '0;
            r_blink_on <= !r_blink_on;
         end else begin
            r_bcnt <= r_bcnt + 1'b1;
         end
      end
   end

   assign o_an  = r_an;
   assign o_seg = r_seg;
   assign o_dp  = r_dp;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - randomized bench against a frame/slot arithmetic model of the scanner
module tb_clock_display_scan;

   localparam int SD = 4;
   localparam int BD = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] ch = 6'd12, cm = 6'd34, cs = 6'd56;
   logic       mode = 1'b1, set = 1'b0, hr = 1'b0, mn = 1'b0, sc = 1'b0;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   // Model: position inside the frame comes from k (edges since reset), blink phase from n (set-run length)
   int         k = 0, n = 0;
   logic [5:0] mh = 0, mm = 0, ms = 0;
   logic [5:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp;

   clock_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_count_h(ch), .i_count_m(cm), .i_count_s(cs),
      .i_mode(mode), .i_set(set), .i_hour(hr), .i_min(mn), .i_sec(sc),
      .o_an(an), .o_seg(seg), .o_dp(dp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (k=%0d)", tag, got, exp, k);
      end
   endtask

   task automatic model_step();
      int scnt, idx, v, d;
      logic blink_on, sel, blank, sep;
      if (reset) begin
         e_an = 6'h3f; e_seg = 7'h7f; e_dp = 1'b1;
         k = 0; n = 0; mh = 0; mm = 0; ms = 0;
      end else begin
         scnt = k % SD;
         idx  = (k / SD) % 6;
         blink_on = ((n / BD) % 2) == 0;
         sel = (idx < 2) ? hr : (idx < 4) ? mn : sc;
         v   = (idx < 2) ? int'(mh) : (idx < 4) ? int'(mm) : int'(ms);
         d   = (idx % 2 == 0) ? v / 10 : v % 10;
         blank = (scnt == 0) || (set && !blink_on && sel);
         sep = (idx == 1) || (idx == 3) || (!mode && idx == 5);
         e_seg = segtab[d];
         e_an  = blank ? 6'h3f : ~(6'b000001 << (5 - idx));
         e_dp  = blank ? 1'b1 : !sep;
         if (k % (6 * SD) == 6 * SD - 1) begin
            mh = ch; mm = cm; ms = cs;
         end
         k++;
         n = set ? n + 1 : 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
   endtask

   initial begin
      repeat (3) cycle();
      reset = 1'b0;
      repeat (12 * SD) cycle();
      cs = 6'd63; cm = 6'd0; ch = 6'd9;
      repeat (12 * SD) cycle();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) cs = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 29) == 0) cm = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 39) == 0) ch = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 59) == 0) mode = ~mode;
         if ($urandom_range(0, 49) == 0) set = ~set;
         if ($urandom_range(0, 29) == 0) {hr, mn, sc} = 3'($urandom_range(0, 7));
         reset = ($urandom_range(0, 399) == 0);
         cycle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
